md5_padder: RTL and testbench



---
 rtl/md5_pkg.sv | 29 ++
 rtl/md5_pad_fill.sv | 30 +++
 rtl/md5_padder.sv | 139 +++++++++++++
 tb/tb_md5_padder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared MD5 front-end definitions: block geometry, pad byte, padder FSM states
// and helpers for the bit-length field and the length-only tail block.
// Imported by md5_pad_fill and md5_padder.
package md5_pkg;

  localparam int         BLK_BYTES = 64;
  localparam int         LEN_OFS   = 56;
  localparam logic [7:0] PAD_BYTE  = 8'h80;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Message bit length, mod 2^64, from a 61-bit byte count.
  function automatic logic [63:0] bit_len(input logic [60:0] byte_cnt);
    return {byte_cnt, 3'b000};
  endfunction

  // Extra block used when the pad byte and/or length did not fit in the last data block.
  function automatic logic [511:0] tail_block(input logic tail80, input logic [63:0] len);
    logic [511:0] blk;
    blk = '0;
    if (tail80) blk[7:0] = PAD_BYTE;
    blk[8*LEN_OFS +: 64] = len;
    return blk;
  endfunction

endpackage

// File: rtl/md5_pad_fill.sv
// Combinational MD5 pad of a partly filled block.
// Ports: i_buf (block with message bytes 0..i_n-1), i_n (bytes used, 1..64),
//        i_bitlen (message length in bits), o_buf (padded block), o_needs_tail.
module md5_pad_fill
  import md5_pkg::*;
(
  input  logic [511:0] i_buf,
  input  logic [6:0]   i_n,
  input  logic [63:0]  i_bitlen,
  output logic [511:0] o_buf,
  output logic         o_needs_tail
);

  always_comb begin
    o_buf        = i_buf;
    // The length field only fits when at least 8 bytes remain after the pad byte.
    o_needs_tail = (i_n >= 7'(LEN_OFS));
    for (int i = 0; i < BLK_BYTES; i++) begin
      if (7'(i) == i_n) begin
        o_buf[i*8 +: 8] = PAD_BYTE;
      end else if (7'(i) > i_n) begin
        o_buf[i*8 +: 8] = 8'h00;
      end
    end
    if (i_n < 7'(LEN_OFS)) begin
      o_buf[8*LEN_OFS +: 64] = i_bitlen;
    end
  end

endmodule

// File: rtl/md5_padder.sv
// MD5 byte-stream padder: collects bytes into one 512-bit block, applies MD5
// padding and emits blocks with valid/ready; blk_last flags the final block.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data/in_last byte
//        input, blk_valid/blk_ready/blk_data/blk_last block output.
module md5_padder
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [5:0]    r_pos;
  logic [60:0]   r_byte_cnt;
  logic [511:0]  r_buf;
  logic          r_blk_valid;
  logic          r_blk_last;
  logic          r_need_tail;
  logic          r_tail80;

  logic          w_accept;
  logic          w_hs;
  logic [60:0]   w_cnt_inc;
  logic [6:0]    w_n;
  logic [63:0]   w_bitlen;
  logic [511:0]  w_buf_wr;
  logic [511:0]  w_buf_pad;
  logic          w_pad_tail;
  logic          w_load_tail;

  assign in_ready  = (r_state == FILL) && !rst;
  assign blk_valid = r_blk_valid;
  assign blk_data  = r_buf;
  assign blk_last  = r_blk_last;

  assign w_accept  = in_valid && in_ready;
  assign w_hs      = r_blk_valid && blk_ready;
  assign w_cnt_inc = r_byte_cnt + 61'd1;
  assign w_n       = {1'b0, r_pos} + 7'd1;
  assign w_bitlen  = bit_len(w_cnt_inc);

  // Buffer with the incoming byte merged at the current position.
  always_comb begin
    w_buf_wr = r_buf;
    w_buf_wr[{r_pos, 3'b000} +: 8] = in_data;
  end

  md5_pad_fill u_pad_fill (
    .i_buf        (w_buf_wr),
    .i_n          (w_n),
    .i_bitlen     (w_bitlen),
    .o_buf        (w_buf_pad),
    .o_needs_tail (w_pad_tail)
  );

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_load_tail = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept && (in_last || r_pos == 6'd63)) w_state_nxt = EMIT;
      end
      EMIT: begin
        if (w_hs) begin
          if (r_need_tail) w_load_tail = 1'b1;
          else             w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos       <= '0;
      r_byte_cnt  <= '0;
      r_buf       <= '0;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      r_need_tail <= 1'b0;
      r_tail80    <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_pos      <= r_pos + 6'd1;
            r_byte_cnt <= w_cnt_inc;
            if (in_last) begin
              r_buf       <= w_buf_pad;
              r_blk_valid <= 1'b1;
              r_blk_last  <= !w_pad_tail;
              r_need_tail <= w_pad_tail;
              // Full block of data: the pad byte itself moves to the tail.
              r_tail80    <= (w_n == 7'd64);
            end else begin
              r_buf <= w_buf_wr;
              if (r_pos == 6'd63) begin
                r_blk_valid <= 1'b1;
                r_blk_last  <= 1'b0;
              end
            end
          end
        end
        EMIT: begin
          if (w_load_tail) begin
            r_buf       <= tail_block(r_tail80, bit_len(r_byte_cnt));
            r_blk_last  <= 1'b1;
            r_need_tail <= 1'b0;
          end else if (w_hs) begin
            // Buffer is zeroed so unwritten bytes of the next block read as 0.
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_buf       <= '0;
            r_pos       <= '0;
            if (r_blk_last) r_byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_padder.sv
module tb_md5_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  md5_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    if (k == 200) chk1("send_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_blk(output logic [511:0] d, output logic l);
    int k;
    k = 0;
    while (!blk_valid && k < 200) begin
      tick();
      k++;
    end
    if (k == 200) chk1("blk_valid_timeout", blk_valid, 1'b1);
    d = blk_data;
    l = blk_last;
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
  endtask

  function automatic logic [511:0] setb(input logic [511:0] b, input int i, input logic [7:0] v);
    logic [511:0] r;
    r = b;
    r[i*8 +: 8] = v;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] d;
    logic [511:0] e;
    logic         l;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    tick();
    tick();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_blk_valid", blk_valid, 1'b0);
    chk1("rst_blk_last", blk_last, 1'b0);
    chk("rst_blk_data", blk_data, 512'd0);
    rst = 1'b0;
    tick();
    chk1("idle_in_ready", in_ready, 1'b1);

    // "abc" with 10 cycles of backpressure
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    chk1("abc_latency_valid", blk_valid, 1'b1);
    chk1("abc_in_ready_low", in_ready, 1'b0);
    e = '0;
    e = setb(e, 0, 8'h61);
    e = setb(e, 1, 8'h62);
    e = setb(e, 2, 8'h63);
    e = setb(e, 3, 8'h80);
    e[511:448] = 64'd24;
    for (int c = 0; c < 10; c++) begin
      chk("bp_data", blk_data, e);
      chk1("bp_valid", blk_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    chk("abc_data", blk_data, e);
    chk1("abc_last", blk_last, 1'b1);
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    chk1("abc_release_in_ready", in_ready, 1'b1);
    chk1("abc_release_valid", blk_valid, 1'b0);

    // 55 bytes of 'A'
    for (int i = 0; i < 55; i++) send(8'h41, i == 54);
    get_blk(d, l);
    e = '0;
    for (int i = 0; i < 55; i++) e = setb(e, i, 8'h41);
    e = setb(e, 55, 8'h80);
    e[511:448] = 64'd440;
    chk("b55_data", d, e);
    chk1("b55_last", l, 1'b1);

    // 56 bytes: pad byte in block 1, length in tail
    for (int i = 0; i < 56; i++) send(8'(i), i == 55);
    get_blk(d, l);
    e = '0;
    for (int i = 0; i < 56; i++) e = setb(e, i, 8'(i));
    e = setb(e, 56, 8'h80);
    chk("b56_blk1_data", d, e);
    chk1("b56_blk1_last", l, 1'b0);
    chk1("b56_tail_latency", blk_valid, 1'b1);
    get_blk(d, l);
    e = '0;
    e[511:448] = 64'd448;
    chk("b56_blk2_data", d, e);
    chk1("b56_blk2_last", l, 1'b1);

    // 64 bytes: raw block, then pad byte + length in tail
    for (int i = 0; i < 64; i++) send(8'(255 - i), i == 63);
    get_blk(d, l);
    e = '0;
    for (int i = 0; i < 64; i++) e = setb(e, i, 8'(255 - i));
    chk("b64_blk1_data", d, e);
    chk1("b64_blk1_last", l, 1'b0);
    get_blk(d, l);
    e = '0;
    e = setb(e, 0, 8'h80);
    e[511:448] = 64'd512;
    chk("b64_blk2_data", d, e);
    chk1("b64_blk2_last", l, 1'b1);
    chk1("b64_in_ready_after", in_ready, 1'b1);

    // Reset mid-message, then "a"
    for (int i = 0; i < 30; i++) send(8'h5a, 1'b0);
    rst = 1'b1;
    tick();
    chk1("midrst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    send(8'h61, 1'b1);
    get_blk(d, l);
    e = '0;
    e = setb(e, 0, 8'h61);
    e = setb(e, 1, 8'h80);
    e[511:448] = 64'd8;
    chk("a_data", d, e);
    chk1("a_last", l, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
